// File: rtl/fetch_queue_pkg.sv
// Shared core definitions for the fetch/decode boundary.
// The packet record is reused by Fetch, Decode and redirect logic.
package fetch_queue_pkg;

    localparam int CORE_XLEN  = 32;
    localparam int CORE_SEQ_W = 8;

    localparam logic [CORE_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [CORE_XLEN-1:0]  pc;
        logic [CORE_XLEN-1:0]  instr;
        logic [CORE_SEQ_W-1:0] seq;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue_chk.sv
// Simulation-only invariants for the fetch queue pointer logic.
module fq_checker #(
    parameter int DEPTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    input logic                   wr_en,
    input logic                   rd_adv,
    input logic                   full,
    input logic                   empty,
    input logic [$clog2(DEPTH):0] head_ptr,
    input logic [$clog2(DEPTH):0] tail_ptr,
    input logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(wr_en && full));
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (reset) !(rd_adv && empty));
    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (reset)
        count == PTR_W'(tail_ptr - head_ptr));

endmodule

// File: rtl/fetch_queue_ptr_ctrl.sv
// Head/tail pointer bookkeeping for the fetch queue: occupancy, full/empty,
// and the qualified write-enable / read-advance strobes.
module fq_ptr_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push_req,
    input  logic                     pop_req,
    output logic                     wr_en,
    output logic                     rd_adv,
    output logic [$clog2(DEPTH)-1:0] wr_idx,
    output logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [$clog2(DEPTH):0]   head_ptr,
    output logic [$clog2(DEPTH):0]   tail_ptr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W-1:0] count_r;
    logic [PTR_W-1:0] head_nxt_s;
    logic [PTR_W-1:0] tail_nxt_s;
    logic [PTR_W-1:0] count_nxt_s;

    // The extra pointer MSB distinguishes a full lap from an empty queue.
    assign empty  = (head_r == tail_r);
    assign full   = (head_r[AW-1:0] == tail_r[AW-1:0]) && (head_r[AW] != tail_r[AW]);
    assign wr_en  = push_req && !full && !flush;
    assign rd_adv = pop_req && !empty && !flush;

    assign wr_idx   = tail_r[AW-1:0];
    assign rd_idx   = head_r[AW-1:0];
    assign head_ptr = head_r;
    assign tail_ptr = tail_r;
    assign count    = count_r;

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (flush) begin
            head_nxt_s  = '0;
            tail_nxt_s  = '0;
            count_nxt_s = '0;
        end else begin
            if (wr_en) begin
                tail_nxt_s = tail_r + PTR_W'(1);
            end else begin
                tail_nxt_s = tail_r;
            end
            if (rd_adv) begin
                head_nxt_s = head_r + PTR_W'(1);
            end else begin
                head_nxt_s = head_r;
            end
            case ({wr_en, rd_adv})
                2'b10:   count_nxt_s = count_r + PTR_W'(1);
                2'b01:   count_nxt_s = count_r - PTR_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO. Stamps each accepted packet with a
// wrapping sequence id; head outputs depend only on stored state.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = CORE_XLEN,
    parameter int SEQ_W = CORE_SEQ_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   enq_valid,
    input  logic [XLEN-1:0]        enq_pc,
    input  logic [XLEN-1:0]        enq_instr,
    output logic                   enq_ready,
    output logic                   deq_valid,
    output logic [XLEN-1:0]        deq_pc,
    output logic [XLEN-1:0]        deq_instr,
    output logic [SEQ_W-1:0]       deq_seq,
    input  logic                   deq_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam fetch_pkt_t EMPTY_PKT = '{pc: '0, instr: NOP_INSTR, seq: '0};

    logic             wr_en;
    logic             rd_adv;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [AW:0]      head_ptr;
    logic [AW:0]      tail_ptr;
    logic             full;
    logic             empty;
    logic [SEQ_W-1:0] seq_ctr_r;
    fetch_pkt_t       mem_r [DEPTH];
    fetch_pkt_t       head_pkt_s;

    fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push_req (enq_valid),
        .pop_req  (deq_ready),
        .wr_en    (wr_en),
        .rd_adv   (rd_adv),
        .wr_idx   (wr_idx),
        .rd_idx   (rd_idx),
        .head_ptr (head_ptr),
        .tail_ptr (tail_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    fq_checker #(.DEPTH(DEPTH)) u_checker (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .rd_adv   (rd_adv),
        .full     (full),
        .empty    (empty),
        .head_ptr (head_ptr),
        .tail_ptr (tail_ptr),
        .count    (count)
    );

    // Entry storage; contents are don't-care after reset or flush.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= '{pc: enq_pc, instr: enq_instr, seq: seq_ctr_r};
        end
    end

    // Sequence stamp survives flush so ids stay monotonic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_ctr_r <= '0;
        end else if (wr_en) begin
            seq_ctr_r <= seq_ctr_r + SEQ_W'(1);
        end else begin
            seq_ctr_r <= seq_ctr_r;
        end
    end

    // Head view: a NOP packet when empty, else the stored head entry.
    always_comb begin
        head_pkt_s = EMPTY_PKT;
        if (empty) begin
            head_pkt_s = EMPTY_PKT;
        end else begin
            head_pkt_s = mem_r[rd_idx];
        end
    end

    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign deq_pc    = head_pkt_s.pc;
    assign deq_instr = head_pkt_s.instr;
    assign deq_seq   = head_pkt_s.seq;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr;
    logic        enq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [7:0]  deq_seq;
    logic        deq_ready;
    logic [3:0]  count;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_queue #(.DEPTH(8), .XLEN(32), .SEQ_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_instr (enq_instr),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_instr (deq_instr),
        .deq_seq   (deq_seq),
        .deq_ready (deq_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_pc    = 32'h0;
        enq_instr = 32'h0;
        deq_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    // Push n packets pc=base+4i, instr=0x1000+i, without popping.
    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            enq_valid = 1'b1;
            enq_pc    = base + 32'(4 * i);
            enq_instr = 32'h0000_1000 + 32'(i);
            step();
        end
        enq_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_enq_ready"}, 32'(enq_ready), 32'h1);
        check_eq({tag, "_deq_valid"}, 32'(deq_valid), 32'h0);
        check_eq({tag, "_count"},     32'(count),     32'h0);
        check_eq({tag, "_deq_instr"}, deq_instr,      NOP);
        check_eq({tag, "_deq_pc"},    deq_pc,         32'h0);
        check_eq({tag, "_deq_seq"},   32'(deq_seq),   32'h0);
    endtask

    initial begin
        // Reset then idle
        do_reset();
        check_idle("reset");

        // Single push, visible the cycle after
        enq_valid = 1'b1;
        enq_pc    = 32'h0;
        enq_instr = 32'h0050_0093;
        check_eq("push1_pre_valid", 32'(deq_valid), 32'h0);
        step();
        enq_valid = 1'b0;
        check_eq("push1_valid", 32'(deq_valid), 32'h1);
        check_eq("push1_pc",    deq_pc,         32'h0);
        check_eq("push1_instr", deq_instr,      32'h0050_0093);
        check_eq("push1_seq",   32'(deq_seq),   32'h0);
        check_eq("push1_count", 32'(count),     32'h1);

        // Fill to 8, 9th offer ignored, drain in order
        do_reset();
        push_n(8, 32'h0);
        check_eq("fill_count", 32'(count),     32'h8);
        check_eq("fill_ready", 32'(enq_ready), 32'h0);
        enq_valid = 1'b1;
        enq_pc    = 32'h100;
        enq_instr = 32'hDEAD_BEEF;
        step();
        enq_valid = 1'b0;
        check_eq("ninth_count", 32'(count), 32'h8);
        check_eq("ninth_head",  deq_pc,     32'h0);
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("drain_pc",    deq_pc,       32'(4 * i));
            check_eq("drain_seq",   32'(deq_seq), 32'(i));
            check_eq("drain_instr", deq_instr,    32'h0000_1000 + 32'(i));
            step();
        end
        deq_ready = 1'b0;
        check_idle("drained");

        // Full with push+pop: only pop, then wrap with push+pop at count 7
        do_reset();
        push_n(8, 32'h0);
        enq_valid = 1'b1;
        enq_pc    = 32'h20;
        enq_instr = 32'h0000_2000;
        deq_ready = 1'b1;
        step();
        check_eq("fullpp_count", 32'(count),     32'h7);
        check_eq("fullpp_head",  deq_pc,         32'h4);
        check_eq("fullpp_ready", 32'(enq_ready), 32'h1);
        step();
        enq_valid = 1'b0;
        check_eq("wrap_count", 32'(count), 32'h7);
        check_eq("wrap_head",  deq_pc,     32'h8);
        for (int i = 0; i < 7; i++) begin
            check_eq("wrap_pc",  deq_pc,       32'h8 + 32'(4 * i));
            check_eq("wrap_seq", 32'(deq_seq), 32'(i + 2));
            step();
        end
        deq_ready = 1'b0;
        check_eq("wrap_empty", 32'(deq_valid), 32'h0);

        // Flush priority and seq continuity
        do_reset();
        push_n(3, 32'h0);
        flush     = 1'b1;
        enq_valid = 1'b1;
        enq_pc    = 32'h80;
        deq_ready = 1'b1;
        step();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check_idle("flush");
        push_n(1, 32'h40);
        check_eq("postflush_seq",   32'(deq_seq), 32'h3);
        check_eq("postflush_pc",    deq_pc,       32'h40);
        check_eq("postflush_count", 32'(count),   32'h1);

        // 300 packets streamed: seq wraps 255 -> 0 with no gap
        do_reset();
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            enq_pc    = 32'(4 * k);
            enq_instr = 32'(k);
            step();
            check_eq("stream_seq",   32'(deq_seq), 32'(k % 256));
            check_eq("stream_pc",    deq_pc,       32'(4 * k));
            check_eq("stream_count", 32'(count),   32'h1);
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;

        // Asynchronous reset mid-cycle with 5 entries
        do_reset();
        push_n(5, 32'h0);
        check_eq("prereset_count", 32'(count), 32'h5);
        #3;
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        step();
        reset = 1'b0;
        step();
        check_idle("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
